// File: rtl/ram_pkg.sv
// Shared types and the byte-merge helper for the simple-dual-port RAM.
// byte_merge works on a fixed maximum width; callers zero-extend and truncate.
package ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ram_state_t;

  localparam int MAX_DW = 256;
  localparam int MAX_BE = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then hands the
// array over to the user ports.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  ram_state_t            state_q;
  logic [ADDR_WIDTH-1:0] clr_ptr_q;
  logic                  init_busy_q;

  // Sequencer state, clear pointer and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      clr_ptr_q   <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          clr_ptr_q <= clr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          if (clr_ptr_q == LAST_ADDR) begin
            state_q     <= RUN;
            init_busy_q <= 1'b0;
          end else begin
            state_q     <= INIT;
            init_busy_q <= 1'b1;
          end
        end
        RUN: begin
          state_q     <= RUN;
          clr_ptr_q   <= clr_ptr_q;
          init_busy_q <= 1'b0;
        end
        default: begin
          state_q     <= INIT;
          clr_ptr_q   <= '0;
          init_busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we    = (state_q == INIT);
  assign clr_addr  = clr_ptr_q;
  assign init_busy = init_busy_q;

endmodule

// File: rtl/sync_sdp_ram.sv
// Synchronous simple-dual-port RAM with byte enables, registered read,
// write-first bypass and a self-clearing array after reset.
module sync_sdp_ram
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    init_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (((DATA_WIDTH % 8) != 0) || (DATA_WIDTH > MAX_DW)) begin : g_width_check
    $fatal(1, "sync_sdp_ram: DATA_WIDTH must be a non-zero multiple of 8 within MAX_DW");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  clr_we_s;
  logic [ADDR_WIDTH-1:0] clr_addr_s;
  logic                  init_busy_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [DATA_WIDTH-1:0] wr_merged_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                  rvalid_d, rvalid_q;

  ram_clear_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_we    (clr_we_s),
    .clr_addr  (clr_addr_s),
    .init_busy (init_busy_s)
  );

  // Write-port mux: the clear sequencer owns the array while busy.
  always_comb begin
    wr_merged_s = DATA_WIDTH'(byte_merge(MAX_DW'(mem_q[waddr]), MAX_DW'(wdata), MAX_BE'(wbe)));
    if (init_busy_s) begin
      mem_we_s    = clr_we_s;
      mem_waddr_s = clr_addr_s;
      mem_wdata_s = INIT_VALUE;
    end else begin
      mem_we_s    = we;
      mem_waddr_s = waddr;
      mem_wdata_s = wr_merged_s;
    end
  end

  // Read path; a same-address write is forwarded so the read sees post-write data.
  always_comb begin
    if (we && (waddr == raddr)) begin
      rd_word_s = wr_merged_s;
    end else begin
      rd_word_s = mem_q[raddr];
    end
    if (init_busy_s) begin
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
    end else if (re) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word_s;
    end else begin
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
    end
  end

  // Array storage; reset edges never write it.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Registered read data and valid flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign init_busy = init_busy_s;

endmodule

// File: tb/tb_sync_sdp_ram.sv
// Scoreboard bench for sync_sdp_ram: directed scenarios plus random traffic
// against an array-based reference model.
module tb_sync_sdp_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  logic        re;
  logic [2:0]  raddr;
  logic [15:0] rdata;
  logic        rvalid;
  logic        init_busy;

  sync_sdp_ram #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(3),
    .INIT_VALUE(16'h0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .wbe       (wbe),
    .re        (re),
    .raddr     (raddr),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    bit          is_rst;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] ref_mem [8];
  int          busy_left = 0;
  logic [15:0] held;
  bit          mon_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard whenever an expected response falls due.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.is_rst) begin
        mon_active = 1'b1;
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        held = 16'h0000;
      end else begin
        chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
        chk("rd_rdata", {16'd0, rdata}, {16'd0, e.data});
        held = e.data;
      end
    end else if (mon_active) begin
      chk("idle_rvalid", {31'd0, rvalid}, 32'd0);
      chk("idle_rdata_hold", {16'd0, rdata}, {16'd0, held});
    end
  end

  // One clock of stimulus; the reference model advances alongside.
  task automatic step(input logic r_n, input logic w, input logic [2:0] wa,
                      input logic [15:0] wd, input logic [1:0] be,
                      input logic rr, input logic [2:0] ra);
    logic        exp_busy;
    logic [15:0] mask;
    logic [15:0] post;
    exp_t        e;
    rst_n = r_n; we = w; waddr = wa; wdata = wd; wbe = be; re = rr; raddr = ra;
    if (!r_n) begin
      e.is_rst = 1'b1; e.data = 16'h0000; e.due = cyc + 1;
      exp_q.push_back(e);
      busy_left = 8;
      for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
      exp_busy = 1'b1;
    end else if (busy_left > 0) begin
      busy_left--;
      exp_busy = (busy_left > 0);
    end else begin
      mask = {be[1] ? 8'hFF : 8'h00, be[0] ? 8'hFF : 8'h00};
      post = (ref_mem[wa] & ~mask) | (wd & mask);
      if (rr) begin
        e.is_rst = 1'b0;
        e.data   = (w && wa == ra) ? post : ref_mem[ra];
        e.due    = cyc + 1;
        exp_q.push_back(e);
      end
      if (w) ref_mem[wa] = post;
      exp_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("init_busy", {31'd0, init_busy}, {31'd0, exp_busy});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0);
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = 3'd0; wdata = 16'h0000; wbe = 2'b00; re = 1'b0; raddr = 3'd0;
    @(negedge clk);

    // 1: reset, clear sequence, read back cleared array
    step(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0);
    idle(8);
    for (int a = 0; a < 8; a++) step(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'(a));
    idle(2);

    // 2: fill with random words, read back to back
    for (int a = 0; a < 8; a++) step(1'b1, 1'b1, 3'(a), 16'($urandom_range(0, 65535)), 2'b11, 1'b0, 3'd0);
    for (int a = 0; a < 8; a++) step(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'(a));
    idle(2);

    // 3: byte enables
    step(1'b1, 1'b1, 3'd2, 16'hA5A5, 2'b11, 1'b0, 3'd0);
    step(1'b1, 1'b1, 3'd2, 16'h1234, 2'b01, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd2);
    step(1'b1, 1'b1, 3'd2, 16'h5A5A, 2'b00, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd2);
    idle(1);
    chk("bytemask_model", {16'd0, ref_mem[2]}, 32'h0000A534);

    // 4: same-address collision, write-first
    step(1'b1, 1'b1, 3'd3, 16'h1111, 2'b11, 1'b0, 3'd0);
    step(1'b1, 1'b1, 3'd3, 16'hBEEF, 2'b10, 1'b1, 3'd3);
    idle(1);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd3);
    idle(1);

    // 5: reset mid-operation, writes ignored during clear
    step(1'b1, 1'b1, 3'd5, 16'hFFFF, 2'b11, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd5, 16'h7777, 2'b11, 1'b1, 3'd5);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'd5, 16'hFFFF, 2'b11, 1'b1, 3'd5);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd5);
    idle(1);

    // 6: rdata holds while no reads are issued
    step(1'b1, 1'b1, 3'd1, 16'h00C3, 2'b11, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'(4 + i), 16'($urandom), 2'b11, 1'b0, 3'd1);
    idle(1);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), 1'($urandom), 3'($urandom), 16'($urandom),
           2'($urandom), 1'($urandom), 3'($urandom));
    end
    idle(12);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
